// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding,
// BCD saturation value and default timing for the 100 MHz board.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    localparam logic [15:0] BCD_MAX       = 16'h5959;
    localparam int unsigned TICK_DIV_DEF  = 100_000_000;
    localparam int unsigned DB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle registered pulse on each rising edge of the debounced level.
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          db_prev_q, db_prev_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        sync1_d   = btn_in;
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = '0;
        cnt_inc   = cnt_q + CW'(1);
        // Counter only runs while the synchronised level disagrees with the
        // accepted level, so any bounce back restarts the stability window.
        if (sync2_q != db_q) begin
            if (cnt_inc == DB_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        db_prev_d = db_q;
        press_d   = db_q & ~db_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/stop and clear buttons drive an
// idle/run/pause/done FSM that issues the 1 Hz count strobe and clear pulse.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter bit          WRAP_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_ss,
    input  logic        btn_clr,
    input  logic [15:0] cntr_in,
    output logic        time_en,
    output logic        cnt_clr,
    output logic        running,
    output logic        done,
    output logic [1:0]  state
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          ss_press;
    logic          clr_press;
    sw_state_e     state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          time_en_q, time_en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          tick_due;
    logic          saturate;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_ss),
        .press  (ss_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_clr),
        .press  (clr_press)
    );

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        time_en_d = 1'b0;
        cnt_clr_d = 1'b0;
        tick_due  = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
        saturate  = !WRAP_EN && (cntr_in == BCD_MAX);
        if (clr_press) begin
            state_d   = ST_IDLE;
            presc_d   = '0;
            cnt_clr_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_press) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (tick_due) begin
                        presc_d = '0;
                        if (saturate) begin
                            state_d = ST_DONE;
                        end else begin
                            time_en_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    // A tick coinciding with a pause is still delivered;
                    // saturation wins over pause.
                    if (ss_press && !(tick_due && saturate)) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (ss_press) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            time_en_q <= 1'b0;
            cnt_clr_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            time_en_q <= time_en_d;
            cnt_clr_q <= cnt_clr_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign time_en = time_en_q;
    assign cnt_clr = cnt_clr_q;
    assign running = running_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DB_CYCLES=4; a second
// instance with WRAP_EN=1 shares all inputs for the saturation comparison.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_ss;
    logic        btn_clr;
    logic [15:0] cntr_in;
    logic        time_en, cnt_clr, running, done;
    logic [1:0]  state;
    logic        w_time_en, w_cnt_clr, w_running, w_done;
    logic [1:0]  w_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(10), .DB_CYCLES(4), .WRAP_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr), .cntr_in(cntr_in),
        .time_en(time_en), .cnt_clr(cnt_clr), .running(running), .done(done), .state(state)
    );

    stopwatch_ctrl #(.TICK_DIV(10), .DB_CYCLES(4), .WRAP_EN(1'b1)) dut_w (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr), .cntr_in(cntr_in),
        .time_en(w_time_en), .cnt_clr(w_cnt_clr), .running(w_running), .done(w_done), .state(w_state)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press lands in the FSM on the 7th posedge after the first sampling edge,
    // so the new state is visible at the 8th negedge.
    task automatic btn_hold(input logic ss, input logic clr);
        btn_ss  = ss;
        btn_clr = clr;
        step(8);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
    endtask

    task automatic test_reset;
        int ticks;
        int moved;
        rst = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0; cntr_in = 16'h0000;
        step(2);
        vectors++;
        if ({time_en, cnt_clr, running, done, state} !== 6'b0) begin
            miscompares++;
            $display("FAIL por_outputs: got %b expected 000000", {time_en, cnt_clr, running, done, state});
        end
        rst = 1'b0;
        step(1);
        btn_hold(1'b1, 1'b0);
        vectors++;
        if (state !== 2'd1 || running !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_start_run: got state=%0d running=%b expected 1/1", state, running);
        end
        step(7);
        rst = 1'b1;
        #1;
        vectors++;
        if ({time_en, cnt_clr, running, done, state} !== 6'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: got %b expected 000000", {time_en, cnt_clr, running, done, state});
        end
        @(negedge clk);
        rst = 1'b0;
        ticks = 0; moved = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (time_en === 1'b1) ticks++;
            if (state !== 2'd0) moved++;
        end
        vectors++;
        if (ticks !== 0 || moved !== 0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got ticks=%0d nonidle=%0d expected 0/0", ticks, moved);
        end
    endtask

    task automatic test_debounce;
        for (int len = 1; len <= 3; len++) begin
            btn_ss = 1'b1;
            step(len);
            btn_ss = 1'b0;
            step(12);
            vectors++;
            if (state !== 2'd0) begin
                miscompares++;
                $display("FAIL glitch_len%0d: got state=%0d expected 0", len, state);
            end
        end
        btn_ss = 1'b1;
        step(7);
        vectors++;
        if (state !== 2'd0) begin
            miscompares++;
            $display("FAIL press_early: got state=%0d expected 0", state);
        end
        step(1);
        vectors++;
        if (state !== 2'd1) begin
            miscompares++;
            $display("FAIL press_latency7: got state=%0d expected 1", state);
        end
        btn_ss = 1'b0;
        step(25);
        vectors++;
        if (state !== 2'd1) begin
            miscompares++;
            $display("FAIL release_no_action: got state=%0d expected 1", state);
        end
        btn_hold(1'b0, 1'b1);
        vectors++;
        if (state !== 2'd0 || cnt_clr !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_from_run: got state=%0d cnt_clr=%b expected 0/1", state, cnt_clr);
        end
        step(1);
        vectors++;
        if (cnt_clr !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_one_cycle: got cnt_clr=%b expected 0", cnt_clr);
        end
        step(6);
    endtask

    task automatic test_tick_timing;
        int cnt, first, prev, gap_bad;
        cnt = 0; first = 0; prev = 0; gap_bad = 0;
        btn_hold(1'b1, 1'b0);
        for (int k = 1; k <= 95; k++) begin
            step(1);
            if (time_en === 1'b1) begin
                if (cnt == 0) first = k;
                else if (k - prev != 10) gap_bad++;
                prev = k;
                cnt++;
            end
        end
        vectors++;
        if (cnt !== 9) begin
            miscompares++;
            $display("FAIL tick_count: got %0d expected 9", cnt);
        end
        vectors++;
        if (first !== 10) begin
            miscompares++;
            $display("FAIL first_tick: got cycle %0d expected 10", first);
        end
        vectors++;
        if (gap_bad !== 0) begin
            miscompares++;
            $display("FAIL tick_spacing: got %0d bad gaps expected 0", gap_bad);
        end
    endtask

    task automatic test_pause_resume;
        int ticks, first;
        // Run has advanced 95 cycles; pause lands 11 cycles later with prescaler=6.
        step(3);
        btn_hold(1'b1, 1'b0);
        vectors++;
        if (state !== 2'd2 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL pause_entry: got state=%0d running=%b expected 2/0", state, running);
        end
        ticks = 0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            if (time_en === 1'b1) ticks++;
        end
        vectors++;
        if (ticks !== 0 || state !== 2'd2) begin
            miscompares++;
            $display("FAIL pause_hold: got ticks=%0d state=%0d expected 0/2", ticks, state);
        end
        btn_hold(1'b1, 1'b0);
        vectors++;
        if (state !== 2'd1) begin
            miscompares++;
            $display("FAIL resume: got state=%0d expected 1", state);
        end
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (time_en === 1'b1 && first == 0) first = k;
        end
        vectors++;
        if (first !== 4) begin
            miscompares++;
            $display("FAIL resume_tick: got cycle %0d expected 4", first);
        end
    endtask

    task automatic test_clear_priority;
        int clr_pulses, run_seen, ticks;
        btn_hold(1'b1, 1'b0);
        vectors++;
        if (state !== 2'd2) begin
            miscompares++;
            $display("FAIL pause_again: got state=%0d expected 2", state);
        end
        step(6);
        clr_pulses = 0; run_seen = 0;
        btn_ss = 1'b1; btn_clr = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 8) begin btn_ss = 1'b0; btn_clr = 1'b0; end
            step(1);
            if (cnt_clr === 1'b1) clr_pulses++;
            if (state === 2'd1) run_seen++;
        end
        vectors++;
        if (clr_pulses !== 1 || run_seen !== 0 || state !== 2'd0) begin
            miscompares++;
            $display("FAIL both_buttons: got clr_pulses=%0d run_seen=%0d state=%0d expected 1/0/0",
                     clr_pulses, run_seen, state);
        end
        btn_hold(1'b1, 1'b0);
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (time_en === 1'b1) ticks++;
        end
        vectors++;
        if (ticks !== 1) begin
            miscompares++;
            $display("FAIL run_before_clr: got ticks=%0d expected 1", ticks);
        end
        // Clear reaches the FSM on the 20th RUN cycle, exactly when a tick is due.
        ticks = 0;
        btn_clr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (time_en === 1'b1) ticks++;
        end
        btn_clr = 1'b0;
        vectors++;
        if (ticks !== 0 || state !== 2'd0 || cnt_clr !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_on_tick: got ticks=%0d state=%0d cnt_clr=%b expected 0/0/1",
                     ticks, state, cnt_clr);
        end
        step(1);
        vectors++;
        if (time_en !== 1'b0 || cnt_clr !== 1'b0) begin
            miscompares++;
            $display("FAIL after_clr_on_tick: got time_en=%b cnt_clr=%b expected 0/0", time_en, cnt_clr);
        end
        step(6);
    endtask

    task automatic test_saturation;
        int ticks, w_ticks;
        btn_hold(1'b1, 1'b0);
        cntr_in = 16'h5959;
        ticks = 0; w_ticks = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (time_en === 1'b1) ticks++;
            if (w_time_en === 1'b1) w_ticks++;
        end
        vectors++;
        if (ticks !== 0 || state !== 2'd3 || done !== 1'b1 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL saturate: got ticks=%0d state=%0d done=%b running=%b expected 0/3/1/0",
                     ticks, state, done, running);
        end
        vectors++;
        if (w_ticks !== 1 || w_state !== 2'd1) begin
            miscompares++;
            $display("FAIL wrap_tick: got ticks=%0d state=%0d expected 1/1", w_ticks, w_state);
        end
        step(6);
        btn_hold(1'b1, 1'b0);
        vectors++;
        if (state !== 2'd3 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_ignores_ss: got state=%0d done=%b expected 3/1", state, done);
        end
        step(6);
        btn_hold(1'b0, 1'b1);
        vectors++;
        if (state !== 2'd0 || cnt_clr !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_clear: got state=%0d cnt_clr=%b done=%b expected 0/1/0", state, cnt_clr, done);
        end
        cntr_in = 16'h0000;
        step(6);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_tick_timing();
        test_pause_resume();
        test_clear_priority();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
